// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: state encodings and frame constants shared by the transmitter and the "11" detector.
package seq_tx_pkg;
    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] PREAMBLE = 2'b01;
    localparam logic [1:0] DATA     = 2'b10;
    localparam logic [1:0] GAP      = 2'b11;
    localparam int PREAMBLE_LEN = 2;
    localparam int GAP_LEN      = 1;
endpackage

// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter (2-cycle 1 preamble, data MSB-first, optional even parity, 0 guard bit).
// Ports: clk, reset (sync, active-high); load_valid/load_data/load_ready word handshake;
// out registered serial line; busy (not IDLE); done (guard-bit pulse); state_out (state encoding).
// Optional feature: define SEQ_TX_PARITY_EN to append an even-parity bit after the data.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_out
);
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             out_n;
`ifdef SEQ_TX_PARITY_EN
    logic             par, par_n, par_ph, par_ph_n;
`endif

    assign load_ready = state == IDLE;
    assign busy       = state != IDLE;
    assign done       = state == GAP;
    assign state_out  = state;

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
`ifdef SEQ_TX_PARITY_EN
        par_n    = par;
        par_ph_n = par_ph;
`endif
        case (state)
            IDLE: if (load_valid) begin
                state_n = PREAMBLE;
                sh_n    = load_data;
                cnt_n   = '0;
`ifdef SEQ_TX_PARITY_EN
                par_n    = ^load_data;
                par_ph_n = 1'b0;
`endif
            end
            PREAMBLE: if (cnt == CW'(PREAMBLE_LEN - 1)) begin
                state_n = DATA;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            DATA: begin
`ifdef SEQ_TX_PARITY_EN
                // parity cycle stays in DATA; a flag selects the parity bit onto the line
                if (par_ph) begin
                    state_n  = GAP;
                    par_ph_n = 1'b0;
                end else begin
                    sh_n = sh << 1;
                    if (cnt == CW'(WIDTH - 1)) par_ph_n = 1'b1;
                    else cnt_n = cnt + 1'b1;
                end
`else
                sh_n = sh << 1;
                if (cnt == CW'(WIDTH - 1)) state_n = GAP;
                else cnt_n = cnt + 1'b1;
`endif
            end
            default: state_n = IDLE;
        endcase
        // out is registered from next-state values so it lines up with the state register
`ifdef SEQ_TX_PARITY_EN
        out_n = (state_n == PREAMBLE) | ((state_n == DATA) & (par_ph_n ? par_n : sh_n[WIDTH-1]));
`else
        out_n = (state_n == PREAMBLE) | ((state_n == DATA) & sh_n[WIDTH-1]);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            out   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par    <= 1'b0;
            par_ph <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            out   <= out_n;
`ifdef SEQ_TX_PARITY_EN
            par    <= par_n;
            par_ph <= par_ph_n;
`endif
        end
    end
endmodule

// File: doc/seq_tx.md
# seq_tx

Serial frame transmitter producing the bit stream consumed by the "11" sequence-detector FSM. Accepts a parallel word over a valid/ready handshake, then drives a single-bit line with a two-cycle `1` preamble, the data MSB-first, an optional parity bit, and a `0` guard bit. Sits on the transmit side of the serial link; its preamble is exactly the pattern the detector locks onto.

## Interface
- `WIDTH`, default 8: data word width; legal range 2 to 32.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `load_valid` input 1: a word is offered on `load_data`.
- `load_data` input WIDTH: word to transmit.
- `load_ready` output 1: block can accept a word; high only in IDLE.
- `out` output 1: registered serial line.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse during the guard bit.
- `state_out` output 2: current state encoding.

## Operation
- States: IDLE=2'b00, PREAMBLE=2'b01, DATA=2'b10, GAP=2'b11.
- IDLE: `out`=0. On `load_valid && load_ready`, capture `load_data` into the shift register, clear the bit counter, and go to PREAMBLE. `load_data` is ignored at all other times.
- PREAMBLE: `out`=1 for exactly 2 cycles, then go to DATA.
- DATA: `out` = shift-register MSB for WIDTH cycles; shift left each cycle. The bit counter is $clog2(WIDTH) bits and is compared against WIDTH-1 to exit. Exit goes to GAP, or to the parity cycle when parity is enabled (see Configuration).
- GAP: `out`=0 and `done`=1 for one cycle, then go to IDLE.
- `load_ready` = (state == IDLE). It is combinational from the state register and does not depend on `load_valid`.
- `busy` = (state != IDLE).
- Reset values: state IDLE, `out`=0, `done`=0, `busy`=0, `load_ready`=1 (after the reset edge), counter 0.
- Reset mid-frame aborts the frame. On the next edge the block returns to IDLE with `out`=0. No `done` pulse is produced and the aborted word is discarded.
- `load_valid` asserted while busy is ignored. The upstream side must hold the word until it sees `load_ready`.

## Timing
- Cycle c=1 is the cycle after the accepting edge.
- c=1..2: `out`=1.
- c=3..WIDTH+2: `out` = data bits WIDTH-1 down to 0.
- Next cycle (parity disabled): GAP, `out`=0, `done`=1.
- Next cycle: IDLE, `load_ready`=1.
- Frame length is WIDTH+3 cycles, or WIDTH+4 with parity.
- Minimum spacing between accepts is frame length + 1 cycle. Consecutive frames are therefore separated by at least two `0` cycles (GAP plus one IDLE cycle).
- `state_out`, `out`, `busy` and `done` are mutually consistent within any cycle; all are derived from the same registered state.

## Configuration
- `SEQ_TX_PARITY_EN` defined: after the last data bit, one extra cycle drives even parity (XOR of the word captured at accept), then GAP. This cycle reports `state_out`=DATA, `busy`=1, `done`=0.
- `SEQ_TX_PARITY_EN` undefined: no parity cycle and no parity register; DATA goes directly to GAP.

## Structure
- Shared package `seq_tx_pkg`:
  - State encodings IDLE/PREAMBLE/DATA/GAP, which the detector side also uses.
  - `PREAMBLE_LEN`=2.
  - `GAP_LEN`=1.
- Single module; no sub-module. The counter and shift register are too small to split out.

## Test plan
- Reset, then idle 5 cycles -> `out`=0, `load_ready`=1, `busy`=0, `state_out`=00 throughout.
- WIDTH=8, accept 8'hA5 -> `out` over c=1..11 = 1,1,1,0,1,0,0,1,0,1,0; `done`=1 only at c=11; `load_ready`=1 at c=12.
- With `SEQ_TX_PARITY_EN`, accept 8'h07 -> c=1..12 = 1,1,0,0,0,0,0,1,1,1,1(parity),0; `done` at c=12.
- `load_valid` held high with a new word during a frame -> new word not captured; the next frame starts only after IDLE, and the second frame's first `1` appears at c=13 of the first frame.
- Assert `reset` at c=5 of an 8'hFF frame -> next cycle `out`=0, state 00, `done` never pulses; a subsequent frame transmits correctly.
- Connect to the "11" detector -> detector reaches state 2'b10 exactly once per frame at the preamble, given the 8'h00 payload.
